// File: rtl/seg_display_driver.sv
// seg_display_driver
//   Samples a 16-bit word on request, converts it to four digits and drives a
//   time-multiplexed 4-digit 7-segment panel.
//
//   The digits are hex by default. Defining SEG_DISPLAY_BCD_EN selects decimal
//   mode: a 16-cycle shift-and-add-3 conversion, with ovf flagging words that
//   do not fit in four decimal digits.
//
//   The conversion works on private registers. The panel reads only the
//   display register, and that register is written once, in COMMIT, so a
//   half-converted value never reaches the segments.

`ifdef SEG_DISPLAY_BCD_EN
// One BCD digit's add-3 correction, applied before each shift.
module seg_bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule
`endif

module seg_display_driver #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        sample,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy,
  output logic        ovf
);

  localparam int NUM_DIGITS = 4;
  localparam int DIV_W      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [3:0] AN_OFF  = {4{SEG_ACTIVE_LOW}};

  logic [1:0]       state;
  logic [15:0]      shadow;
  logic [15:0]      disp;
  logic [1:0]       idx;
  logic [DIV_W-1:0] div;

  // Active-high glyph for one digit, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  assign busy = (state != S_IDLE);

`ifdef SEG_DISPLAY_BCD_EN
  // 20-bit accumulator; bits [19:16] hold the ten-thousands digit.
  logic [19:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  bit_cnt;

  // Only the low four digits need correcting. The top digit is at most 3
  // before the final shift, and no correction follows that shift.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    seg_bcd_adj3 u_adj (
      .din  (bcd[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Capture FSM: sample -> 16 double-dabble shifts -> commit to the panel.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      shadow  <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      disp    <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sample) begin
            shadow  <= value;
            bcd     <= '0;
            bit_cnt <= '0;
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          bcd     <= {bcd[18:16], bcd_adj, shadow[15]};
          shadow  <= {shadow[14:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) state <= S_COMMIT;
        end
        S_COMMIT: begin
          disp  <= bcd[15:0];
          ovf   <= (bcd[19:16] != 4'd0);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  logic [15:0] digits;

  assign ovf = 1'b0;

  // Capture FSM: sample -> copy nibbles -> commit to the panel.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      shadow <= '0;
      digits <= '0;
      disp   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sample) begin
            shadow <= value;
            state  <= S_CONV;
          end
        end
        S_CONV: begin
          digits <= shadow;
          state  <= S_COMMIT;
        end
        S_COMMIT: begin
          disp  <= digits;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`endif

  // Scan: free-running divider that steps the digit index and registers seg/an.
  always_ff @(posedge clock) begin
    if (reset) begin
      div <= '0;
      idx <= '0;
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= glyph(disp[{idx, 2'b00} +: 4]) ^ SEG_OFF;
      an  <= (4'b0001 << idx) ^ AN_OFF;
      if (div == DIV_LAST) begin
        div <= '0;
        idx <= idx + 2'd1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// tb_seg_display_driver
//   Directed and random stimulus for seg_display_driver. A behavioural model
//   tracks the panel from plain arithmetic: cycles since reset, request
//   latency, and the value's hex or decimal digits. seg, an, busy and ovf are
//   checked on every cycle. The build follows SEG_DISPLAY_BCD_EN.

module tb_seg_display_driver;
  localparam int DIV = 4;
  localparam bit AL  = 1'b1;
`ifdef SEG_DISPLAY_BCD_EN
  localparam int LAT = 17;
  localparam bit BCD = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BCD = 1'b0;
`endif

  localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        sample;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;
  logic        ovf;

  int          n_assert = 0;
  int          n_fail   = 0;

  int          cnt;
  int          m_left;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_ovf;

  always #5 clock = ~clock;

  seg_display_driver #(.REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(AL)) dut (
    .clock  (clock),
    .reset  (reset),
    .value  (value),
    .sample (sample),
    .seg    (seg),
    .an     (an),
    .busy   (busy),
    .ovf    (ovf)
  );

  function automatic logic [15:0] to_disp(input logic [15:0] v);
    int r;
    if (!BCD) return v;
    r = int'(v) % 10000;
    return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, act, exp, cnt);
    end
  endtask

  // One clock: advance the model across the edge, then check all outputs.
  task automatic tick();
    logic [15:0] disp_pre;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    int          i;
    disp_pre = m_disp;
    @(posedge clock);
    if (reset) begin
      cnt = 0; m_left = 0; m_disp = '0; m_ovf = 1'b0;
    end else begin
      cnt++;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_disp = to_disp(m_pend);
          m_ovf  = BCD && (m_pend >= 16'd10000);
        end
      end else if (sample) begin
        m_pend = value;
        m_left = LAT;
      end
    end
    #1;
    if (cnt == 0) begin
      e_seg = AL ? 7'h7F : 7'h00;
      e_an  = AL ? 4'hF : 4'h0;
    end else begin
      i     = ((cnt - 1) / DIV) % 4;
      e_seg = GLY[disp_pre[i*4 +: 4]];
      e_an  = 4'(1 << i);
      if (AL) begin
        e_seg = ~e_seg;
        e_an  = ~e_an;
      end
    end
    chk("seg",  16'(seg),  16'(e_seg));
    chk("an",   16'(an),   16'(e_an));
    chk("busy", 16'(busy), 16'(m_left > 0));
    chk("ovf",  16'(ovf),  16'(m_ovf));
  endtask

  // Pulse sample for one cycle, wait out the conversion, then scan all digits.
  task automatic do_sample(input logic [15:0] v);
    value  = v;
    sample = 1'b1;
    tick();
    sample = 1'b0;
    value  = 16'($urandom);
    repeat (LAT + 1) tick();
    repeat (4 * DIV) tick();
  endtask

  initial begin
    cnt = 0; m_left = 0; m_disp = '0; m_pend = '0; m_ovf = 1'b0;
    reset = 1'b1; sample = 1'b0; value = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5 * DIV + 2) tick();

    do_sample(16'hBEEF);
    do_sample(16'd1234);
    do_sample(16'd65535);
    do_sample(16'd42);
    do_sample(16'd9999);
    do_sample(16'd10000);
    do_sample(16'd0);

    // Back-to-back requests: the second lands while busy and is dropped.
    value = 16'h1111; sample = 1'b1; tick();
    value = 16'h2222; tick();
    sample = 1'b0;
    repeat (LAT + 4 * DIV + 2) tick();

    // Reset in the middle of a conversion.
    value = 16'd54321; sample = 1'b1; tick();
    sample = 1'b0; value = 16'hFFFF;
    repeat (8) tick();
    reset = 1'b1; tick();
    reset = 1'b0;
    repeat (4 * DIV + 2) tick();
    do_sample(16'd8765);

    // Random traffic, with changing values and occasional resets.
    for (int k = 0; k < 600; k++) begin
      value  = 16'($urandom);
      sample = ($urandom_range(0, 5) == 0);
      reset  = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; sample = 1'b0;
    repeat (LAT + 4 * DIV + 2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
